// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
// States, opcodes and the datapath mux/ALU encodings live here.
package riscv_ctrl_pkg;

  localparam int ST_BITS = 4;

  typedef enum logic [ST_BITS-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JLINK    = 4'd12,
    S_LUI      = 4'd13,
    S_HALT     = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_IALU   = 7'h13;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] F3_WORD = 3'b010;

  // beq/bne/blt/bge only; the unsigned compares are not supported.
  function automatic logic branch_f3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, selects/enables out.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero;
  logic       sign;

  logic       PCWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [2:0] ImmSrc;
  logic       retire;
  logic       illegal;

  modport master (
    input  opcode, func3, func7, zero, sign,
    output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, retire, illegal
  );

  modport slave (
    output opcode, func3, func7, zero, sign,
    input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, retire, illegal
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational func3/func7 decode for R-type and I-ALU instructions.
// bad_funct flags encodings outside the supported subset.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic       is_rtype,
  input  logic [2:0] func3,
  input  logic       func7_5,
  output logic [2:0] alu_control,
  output logic       bad_funct
);

  always_comb begin
    alu_control = ALU_ADD;
    bad_funct   = 1'b0;
    case (func3)
      3'b000: alu_control = (is_rtype && func7_5) ? ALU_SUB : ALU_ADD;
      3'b010: alu_control = ALU_SLT;
      3'b100: alu_control = ALU_XOR;
      3'b110: alu_control = ALU_OR;
      3'b111: alu_control = ALU_AND;
      default: bad_funct  = 1'b1;
    endcase
    // func7[5] only selects sub; on any other R-type func3 it is an unsupported op
    if (is_rtype && func7_5 && (func3 != 3'b000))
      bad_funct = 1'b1;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: one state per cycle, Moore decode of the
// datapath selects/enables, with PCWrite in BRANCH qualified by zero/sign.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.master bus
);

  logic [STATE_W-1:0] state_q;
  state_t             cur;
  state_t             nxt;

  logic       is_rtype;
  logic [2:0] dec_alu;
  logic       bad_funct;
  logic       unused_f7;

  logic       pc_write;
  logic       adr_src;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [2:0] imm_src;
  logic       retire;
  logic       illegal;

  assign cur       = state_t'(state_q);
  assign is_rtype  = (bus.opcode == OP_RTYPE);
  assign unused_f7 = ^{bus.func7[6], bus.func7[4:0]};

  alu_decoder u_alu_decoder (
    .is_rtype    (is_rtype),
    .func3       (bus.func3),
    .func7_5     (bus.func7[5]),
    .alu_control (dec_alu),
    .bad_funct   (bad_funct)
  );

  always_comb begin
    nxt = S_HALT;
    case (cur)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: nxt = (bus.func3 == F3_WORD) ? S_MEMADR : S_HALT;
          OP_RTYPE:          nxt = bad_funct ? S_HALT : S_EXECR;
          OP_IALU:           nxt = bad_funct ? S_HALT : S_EXECI;
          OP_BRANCH:         nxt = branch_f3_ok(bus.func3) ? S_BRANCH : S_HALT;
          OP_JAL:            nxt = S_JAL;
          OP_JALR:           nxt = (bus.func3 == 3'b000) ? S_JALR : S_HALT;
          OP_LUI:            nxt = S_LUI;
          default:           nxt = S_HALT;
        endcase
      end
      S_MEMADR:   nxt = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  nxt = S_MEMWB;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: nxt = S_FETCH;
      S_EXECR:    nxt = S_ALUWB;
      S_EXECI:    nxt = S_ALUWB;
      S_LUI:      nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_BRANCH:   nxt = S_FETCH;
      S_JAL:      nxt = S_ALUWB;
      S_JALR:     nxt = S_JLINK;
      S_JLINK:    nxt = S_FETCH;
      default:    nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= STATE_W'(S_FETCH);
    else
      state_q <= STATE_W'(nxt);
  end

  // Output decode; rst masks everything so no write can slip out mid-instruction.
  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_REGB;
    alu_control = ALU_ADD;
    imm_src     = IMM_I;
    retire      = 1'b0;
    illegal     = 1'b0;
    case (cur)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        pc_write   = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (bus.opcode == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_REGA;
        alu_src_b = SRCB_IMM;
        imm_src   = (bus.opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = SRCA_REGA;
        alu_src_b   = SRCB_REGB;
        alu_control = dec_alu;
      end
      S_EXECI: begin
        alu_src_a   = SRCA_REGA;
        alu_src_b   = SRCB_IMM;
        alu_control = dec_alu;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = SRCA_REGA;
        alu_control = ALU_SUB;
        retire      = 1'b1;
        case (bus.func3)
          3'b000:  pc_write = bus.zero;
          3'b001:  pc_write = ~bus.zero;
          3'b100:  pc_write = bus.sign;
          default: pc_write = ~bus.sign;
        endcase
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_JALR: begin
        alu_src_a  = SRCA_REGA;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURES;
        pc_write   = 1'b1;
      end
      S_JLINK: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_HALT:  illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
    if (rst) begin
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_control = 3'b000;
      imm_src     = 3'b000;
      retire      = 1'b0;
      illegal     = 1'b0;
    end
  end

  assign bus.PCWrite    = pc_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.IRWrite    = ir_write;
  assign bus.MemWrite   = mem_write;
  assign bus.RegWrite   = reg_write;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = imm_src;
  assign bus.retire     = retire;
  assign bus.illegal    = illegal;

endmodule
